// File: rtl/seq_subtractor_pkg.sv
// Shared types and defaults for the slice-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_subtractor_pkg;

  // Default operand width and bits handled per clock.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 16;

  // Controller states: waiting for operands, slicing, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width: enough to count 0..nslice-1, never below one bit.
  function automatic int idx_bits(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_subtractor_sub_slice.sv
// One slice of the subtract datapath: {c_out, d} = a + ~b + c_in.
// Latency: purely combinational.
// Backpressure: none; driven and consumed by the owning controller.
module sub_slice #(
  parameter int W = 16
) (
  output logic [W-1:0] d,
  output logic         c_out,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in
);

  // Carry-in of 1 with an inverted subtrahend forms the two's complement;
  // a carry-out of 1 therefore means "no borrow" out of this slice.
  assign {c_out, d} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c_in};

endmodule

// File: rtl/seq_subtractor.sv
// Slice-serial a - b - b_in, LSB slice first, with flags (b_out, ovf, zero).
// Latency: result valid NSLICE cycles after acceptance; initiation interval NSLICE+2.
// Backpressure: out_valid holds with stable outputs until out_ready; in_ready low meanwhile.
module seq_subtractor
  import seq_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  // WIDTH is expected to be a whole multiple of SLICE.
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_bits(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;      // 1 = no borrow pending into the next slice
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] d_sl;
  logic             c_sl;
  logic [WIDTH-1:0] diff_nxt;

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Pick the operand slices addressed by the slice counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDX_W'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  sub_slice #(
    .W (SLICE)
  ) u_slice (
    .d     (d_sl),
    .c_out (c_sl),
    .a     (a_sl),
    .b     (b_sl),
    .c_in  (carry)
  );

  // Merge the fresh slice into the running difference; also feeds the flags on the last slice.
  always_comb begin
    diff_nxt = diff;
    for (int k = 0; k < NSLICE; k++) begin
      if (idx == IDX_W'(k)) begin
        diff_nxt[k*SLICE +: SLICE] = d_sl;
      end
    end
  end

  // Controller: accept operands, walk the slices, hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= a;
            b_q   <= b;
            carry <= ~b_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_nxt;
          carry <= c_sl;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= DONE;
            b_out <= ~c_sl;
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                     (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
            zero  <= (diff_nxt == '0);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // A simultaneous in_valid here is deliberately not taken; it is accepted from IDLE.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Self-checking bench for seq_subtractor: scoreboard queue filled at acceptance, drained by a monitor.
// Latency: n/a.
// Backpressure: out_ready is forced or randomised by the bench.
module tb_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        b_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] diff;
  logic        b_out;
  logic        ovf;
  logic        zero;

  typedef struct {
    logic [31:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   cons_cyc = -1;
  bit   rand_rdy = 1'b0;
  bit   force_rdy = 1'b1;
  bit   prev_v   = 1'b0;

  seq_subtractor dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .b_out     (b_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer side: random or forced ready, changed just after each edge.
  always @(posedge clk) begin
    #1;
    out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : force_rdy;
  end

  // Reference: plain integer arithmetic on the mathematical result.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic bi, input int acc);
    exp_t   e;
    longint ua, ub, sa, sbv, sr, maxv, minv;
    ua   = longint'(x);
    ub   = longint'(y);
    sa   = longint'($signed(x));
    sbv  = longint'($signed(y));
    maxv = (longint'(1) <<< 31) - 1;
    minv = -(longint'(1) <<< 31);
    sr   = sa - sbv - longint'(bi);
    e.diff  = 32'(ua - ub - longint'(bi));
    e.b_out = (ua < ub + longint'(bi));
    e.ovf   = (sr > maxv) || (sr < minv);
    e.zero  = (e.diff == 32'd0);
    e.acc   = acc;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, result compare on consumption.
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, expected no result", cyc);
        end else begin
          chk("latency", 32'(cyc), 32'(sb[0].acc + 2));
        end
      end
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("diff", diff, e.diff);
        chk1("b_out", b_out, e.b_out);
        chk1("ovf", ovf, e.ovf);
        chk1("zero", zero, e.zero);
        cons_cyc = cyc + 1;
      end
      prev_v = out_valid;
    end
  end

  // Present operands at a falling edge and wait for in_ready; record the acceptance edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic bi, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      a = x; b = y; b_in = bi; in_valid = 1'b1;
      if (in_ready) begin
        acc = cyc + 1;
        sb.push_back(model(x, y, bi, acc));
        ok = 1'b1;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    // Garbage on the operand bus while the op runs must not matter.
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    b_in = 1'($urandom_range(0, 1));
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got in_ready=0 for 100 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc0, acc1;
    exp_t        ebp;
    bit          seen;
    logic [31:0] sp [4];
    logic [31:0] x, y;
    sp[0] = 32'h0000_0000;
    sp[1] = 32'hFFFF_FFFF;
    sp[2] = 32'h8000_0000;
    sp[3] = 32'h7FFF_FFFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff", diff, 32'd0);
    chk1("rst_b_out", b_out, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_zero", zero, 1'b0);

    // Directed operand patterns
    issue(32'd5, 32'd3, 1'b0, acc0);
    issue(32'd0, 32'd1, 1'b0, acc0);
    issue(32'h8000_0000, 32'd1, 1'b0, acc0);
    issue(32'h0001_0000, 32'd1, 1'b0, acc0);
    issue(32'h1234_5678, 32'h1234_5678, 1'b0, acc0);
    issue(32'h1234_5678, 32'h1234_5678, 1'b1, acc0);
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, acc0);
    drain();

    // Back-to-back initiation interval with out_ready held high
    issue(32'd1, 32'd2, 1'b0, acc0);
    issue(32'd3, 32'd4, 1'b1, acc1);
    chk("min_ii", 32'(acc1 - acc0), 32'd4);
    drain();

    // Back-pressure: result held stable, busy, new operands ignored
    force_rdy = 1'b0;
    @(posedge clk);
    #2;
    issue(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, acc0);
    ebp  = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, acc0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk1("bp_out_valid_seen", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_diff", diff, ebp.diff);
      chk1("bp_b_out", b_out, ebp.b_out);
      chk1("bp_ovf", ovf, ebp.ovf);
      chk1("bp_zero", zero, ebp.zero);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk1("bp_out_valid", out_valid, 1'b1);
      in_valid = ~in_valid;
      a = $urandom;
    end
    // Release with in_valid already high: consumed first, accepted one edge later
    force_rdy = 1'b1;
    in_valid  = 1'b1;
    a = 32'd100;
    b = 32'd1;
    b_in = 1'b0;
    issue(32'd100, 32'd1, 1'b0, acc1);
    chk("accept_after_consume", 32'(acc1), 32'(cons_cyc + 1));
    drain();

    // Reset during RUN after the first slice
    issue(32'h0000_0055, 32'h0001_0022, 1'b0, acc0);
    @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("abort_in_ready", in_ready, 1'b1);
    chk1("abort_out_valid", out_valid, 1'b0);
    chk("abort_diff", diff, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("abort_no_valid", out_valid, 1'b0);
    end
    issue(32'd10, 32'd4, 1'b0, acc0);
    drain();

    // Randomised operands with random back-pressure and gaps
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      x = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = x;
      issue(x, y, 1'($urandom_range(0, 1)), acc0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    @(posedge clk);
    #2 rand_rdy = 1'b0;

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_results: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
